// File: rtl/mult_acc_pipe.sv
// mult_acc_pipe: pipelined signed/unsigned multiply-accumulate with valid/ready back-pressure.
// Define MULT_ACC_PIPE_SAT_EN to make accumulation saturate instead of wrapping.
module mult_acc_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  signed_mode,
    input  logic                  mac_mode,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out,
    output logic                  overflow
);
    localparam int PW = 2*DATA_WIDTH;
    localparam int L  = PIPE_STAGES - 1;
    logic                   adv;
    logic                   s0_v, s0_sg, s0_mac, s0_clr;
    logic [DATA_WIDTH-1:0]  s0_a, s0_b;
    logic [PW-1:0]          ax, bx, prod;
    logic [PW-1:0]          pp [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] pv, psg, pmac, pclr;
    logic [ACC_WIDTH-1:0]   ext, sum, acc, acc_nxt;
    logic                   carry, ovf;

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) s0_v <= 1'b0;
        else if (adv) s0_v <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s0_a   <= a;
            s0_b   <= b;
            s0_sg  <= signed_mode;
            s0_mac <= mac_mode;
            s0_clr <= acc_clr;
        end
    end

    // Low 2*DATA_WIDTH bits of the product of width-extended operands equal the signed product.
    assign ax   = s0_sg ? PW'($signed(s0_a)) : PW'(s0_a);
    assign bx   = s0_sg ? PW'($signed(s0_b)) : PW'(s0_b);
    assign prod = ax * bx;

    always_ff @(posedge clk) begin
        if (rst) pv <= '0;
        else if (adv) begin
            pv[0] <= s0_v;
            for (int i = 1; i < PIPE_STAGES; i++) pv[i] <= pv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            pp[0]   <= prod;
            psg[0]  <= s0_sg;
            pmac[0] <= s0_mac;
            pclr[0] <= s0_clr;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pp[i]   <= pp[i-1];
                psg[i]  <= psg[i-1];
                pmac[i] <= pmac[i-1];
                pclr[i] <= pclr[i-1];
            end
        end
    end

    assign ext          = psg[L] ? ACC_WIDTH'($signed(pp[L])) : ACC_WIDTH'(pp[L]);
    assign {carry, sum} = {1'b0, acc} + {1'b0, ext};
    assign ovf          = psg[L] ? (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) & (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1])
                                 : carry;
`ifdef MULT_ACC_PIPE_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    assign acc_nxt = ~ovf ? sum : psg[L] ? (acc[ACC_WIDTH-1] ? SMIN : SMAX) : '1;
`else
    assign acc_nxt = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
        end else if (adv) begin
            out_valid <= pv[L];
            if (pv[L]) begin
                if (!pmac[L]) begin
                    out <= ext;
                end else if (pclr[L]) begin
                    acc      <= ext;
                    out      <= ext;
                    overflow <= 1'b0;
                end else begin
                    acc      <= acc_nxt;
                    out      <= acc_nxt;
                    overflow <= overflow | ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_acc_pipe.sv
// tb_mult_acc_pipe: directed and randomized checks of mult_acc_pipe against a behavioural MAC model.
module tb_mult_acc_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;

    logic        v16, r16, sg16, mac16, clr16, ov16, or16, of16;
    logic [15:0] a16, b16;
    logic [39:0] o16;
    logic        v8, r8, sg8, mac8, clr8, ov8, or8, of8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;

    mult_acc_pipe d16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .signed_mode(sg16), .mac_mode(mac16), .acc_clr(clr16),
        .out_valid(ov16), .out_ready(or16), .out(o16), .overflow(of16)
    );

    mult_acc_pipe #(.DATA_WIDTH(8), .PIPE_STAGES(1), .ACC_WIDTH(16)) d8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .signed_mode(sg8), .mac_mode(mac8), .acc_clr(clr8),
        .out_valid(ov8), .out_ready(or8), .out(o8), .overflow(of8)
    );

    typedef struct { longint val; bit ov; } res_t;
    longint m_acc;
    bit     m_ov;

    function automatic longint sval(longint x, int w);
        return x >= (longint'(1) << (w-1)) ? x - (longint'(1) << w) : x;
    endfunction

    // Mathematical MAC: true product and sum, range test for overflow, then wrap or clamp.
    function automatic res_t model(int dw, int aw, longint av, longint bv, bit sg, bit mac, bit clr);
        longint p, t, lim;
        res_t r;
        lim = longint'(1) << aw;
        p = sg ? sval(av, dw) * sval(bv, dw) : av * bv;
        if (!mac) r.val = p & (lim - 1);
        else if (clr) begin
            m_acc = p & (lim - 1);
            m_ov  = 1'b0;
            r.val = m_acc;
        end else begin
            t = sg ? sval(m_acc, aw) + p : m_acc + p;
            if (sg ? (t >= lim/2 || t < -lim/2) : (t >= lim)) begin
                m_ov = 1'b1;
`ifdef MULT_ACC_PIPE_SAT_EN
                t = sg ? (t < 0 ? -lim/2 : lim/2 - 1) : lim - 1;
`endif
            end
            m_acc = t & (lim - 1);
            r.val = m_acc;
        end
        r.ov = m_ov;
        return r;
    endfunction

    task automatic drive16(input bit v, input logic [15:0] a, input logic [15:0] b, input bit sg, input bit mac, input bit clr);
        v16 = v; a16 = a; b16 = b; sg16 = sg; mac16 = mac; clr16 = clr;
    endtask

    task automatic drive8(input bit v, input logic [7:0] a, input logic [7:0] b, input bit sg, input bit mac, input bit clr);
        v8 = v; a8 = a; b8 = b; sg8 = sg; mac8 = mac; clr8 = clr;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive16(0, 0, 0, 0, 0, 0);
        drive8(0, 0, 0, 0, 0, 0);
        or16 = 1'b1;
        or8  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ov16 !== 1'b0 || o16 !== 40'd0 || of16 !== 1'b0 || r16 !== 1'b1) begin
            errors++;
            $display("FAIL reset16: out_valid=%b out=%h overflow=%b in_ready=%b, want 0 0 0 1", ov16, o16, of16, r16);
        end
        checks++;
        if (ov8 !== 1'b0 || o8 !== 16'd0 || of8 !== 1'b0 || r8 !== 1'b1) begin
            errors++;
            $display("FAIL reset8: out_valid=%b out=%h overflow=%b in_ready=%b, want 0 0 0 1", ov8, o8, of8, r8);
        end
    endtask

    task automatic test_multiply;
        logic [15:0] ta [2]   = '{16'hFFFF, 16'hFFFE};
        logic [15:0] tbv [2]  = '{16'hFFFF, 16'h0003};
        bit          tsg [2]  = '{1'b0, 1'b1};
        logic [39:0] texp [2] = '{40'h00FFFE0001, 40'hFFFFFFFFFA};
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k <= 6; k++) begin
                @(negedge clk);
                if (k == 0) drive16(1, ta[t], tbv[t], tsg[t], 0, 0);
                else drive16(0, 0, 0, 0, 0, 0);
                #1;
                if (k == 0) begin
                    checks++;
                    if (r16 !== 1'b1) begin errors++; $display("FAIL mul%0d_accept: in_ready=%b want 1", t, r16); end
                end
                checks++;
                if (ov16 !== 1'(k == 4)) begin
                    errors++;
                    $display("FAIL mul%0d_latency: cycle %0d out_valid=%b want %b", t, k, ov16, k == 4);
                end
                if (k == 4) begin
                    checks++;
                    if (o16 !== texp[t] || of16 !== 1'b0) begin
                        errors++;
                        $display("FAIL mul%0d_value: out=%h overflow=%b want %h 0", t, o16, of16, texp[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_mac;
        logic [15:0] ta [3]   = '{16'd3, 16'd5, 16'hFFFE};
        logic [15:0] tbv [3]  = '{16'd4, 16'd6, 16'd7};
        bit          tclr [3] = '{1'b1, 1'b0, 1'b0};
        logic [39:0] texp [3] = '{40'd12, 40'd42, 40'd28};
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k < 3) drive16(1, ta[k], tbv[k], 1, 1, tclr[k]);
            else drive16(0, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (ov16 !== 1'(k >= 4 && k <= 6)) begin
                errors++;
                $display("FAIL mac_valid: cycle %0d out_valid=%b want %b", k, ov16, k >= 4 && k <= 6);
            end
            if (k >= 4 && k <= 6) begin
                checks++;
                if (o16 !== texp[k-4] || of16 !== 1'b0) begin
                    errors++;
                    $display("FAIL mac_value: beat %0d out=%h overflow=%b want %h 0", k - 4, o16, of16, texp[k-4]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        bit stalled = 1'b0;
        logic [39:0] held = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            or16 = !(c >= 6 && c < 11);
            if (sent < 8) drive16(1, 16'(sent), 16'd1, 0, 0, 0);
            else drive16(0, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (r16 !== !(ov16 && !or16)) begin
                errors++;
                $display("FAIL bp_ready: cycle %0d in_ready=%b want %b", c, r16, !(ov16 && !or16));
            end
            if (c == 6) begin
                checks++;
                if (ov16 !== 1'b1 || r16 !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stall_start: out_valid=%b in_ready=%b want 1 0", ov16, r16);
                end
            end
            if (stalled) begin
                checks++;
                if (o16 !== held || ov16 !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d out=%h out_valid=%b want %h 1", c, o16, ov16, held);
                end
            end
            if (v16 && r16) sent++;
            if (ov16 && or16) begin
                checks++;
                if (o16 !== 40'(got)) begin
                    errors++;
                    $display("FAIL bp_order: out=%h want %h", o16, 40'(got));
                end
                got++;
            end
            stalled = ov16 && !or16;
            held = o16;
        end
        or16 = 1'b1;
        drive16(0, 0, 0, 0, 0, 0);
        checks++;
        if (got != 8) begin errors++; $display("FAIL bp_count: delivered %0d want 8", got); end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (ov16 !== 1'b0) begin errors++; $display("FAIL bp_extra: out_valid=%b want 0", ov16); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0]  ta [6]   = '{8'd255, 8'd255, 8'd255, 8'd1, 8'd255, 8'd255};
        bit          tclr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bit          eo [6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] texp [6];
`ifdef MULT_ACC_PIPE_SAT_EN
        texp = '{16'hFE01, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFE01, 16'hFFFF};
`else
        texp = '{16'hFE01, 16'hFC02, 16'hFA03, 16'h0001, 16'hFE01, 16'hFC02};
`endif
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 6) drive8(1, ta[k], ta[k], 0, 1, tclr[k]);
            else drive8(0, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (ov8 !== 1'(k >= 3 && k <= 8)) begin
                errors++;
                $display("FAIL ovf_valid: cycle %0d out_valid=%b want %b", k, ov8, k >= 3 && k <= 8);
            end
            if (k >= 3 && k <= 8) begin
                checks++;
                if (o8 !== texp[k-3] || of8 !== eo[k-3]) begin
                    errors++;
                    $display("FAIL ovf_value: beat %0d out=%h overflow=%b want %h %b", k - 3, o8, of8, texp[k-3], eo[k-3]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight;
        checks++;
        if (of8 !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf: overflow=%b want 1", of8); end
        @(negedge clk);
        drive16(1, 16'd3, 16'd3, 0, 0, 0);
        #1;
        checks++;
        if (r16 !== 1'b1) begin errors++; $display("FAIL rst_accept: in_ready=%b want 1", r16); end
        @(negedge clk);
        drive16(1, 16'd4, 16'd4, 0, 0, 0);
        @(negedge clk);
        drive16(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (ov16 !== 1'b0 || o16 !== 40'd0 || of16 !== 1'b0 || r16 !== 1'b1 || ov8 !== 1'b0 || of8 !== 1'b0) begin
                errors++;
                $display("FAIL rst_flush: cycle %0d out_valid=%b out=%h overflow=%b in_ready=%b d8 out_valid=%b overflow=%b want 0 0 0 1 0 0",
                         k, ov16, o16, of16, r16, ov8, of8);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        res_t q[$];
        res_t e;
        int n = 0;
        bit pend = 1'b0;
        m_acc = 0;
        m_ov  = 1'b0;
        for (int c = 0; c < 3000 && (n < 200 || q.size() > 0); c++) begin
            @(negedge clk);
            if (!pend) begin
                if (n < 200 && $urandom_range(3) != 0)
                    drive8(1, 8'($urandom), 8'($urandom), 1'($urandom), n == 0 || $urandom_range(3) != 0,
                           n == 0 || $urandom_range(7) == 0);
                else drive8(0, 0, 0, 0, 0, 0);
            end
            or8 = $urandom_range(3) != 0;
            #1;
            if (ov8 && or8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: out=%h with nothing outstanding", o8);
                end else begin
                    e = q.pop_front();
                    if (o8 !== 16'(e.val) || of8 !== e.ov) begin
                        errors++;
                        $display("FAIL rand_value: out=%h overflow=%b want %h %b", o8, of8, 16'(e.val), e.ov);
                    end
                end
            end
            pend = v8 && !r8;
            if (v8 && r8) begin
                q.push_back(model(8, 16, longint'(a8), longint'(b8), sg8, mac8, clr8));
                n++;
            end
        end
        drive8(0, 0, 0, 0, 0, 0);
        or8 = 1'b1;
        checks++;
        if (q.size() != 0 || n != 200) begin
            errors++;
            $display("FAIL rand_drain: sent %0d outstanding %0d want 200 0", n, q.size());
        end
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_mac;
        test_backpressure;
        test_overflow;
        test_reset_midflight;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mult_acc_pipe.md
Name: mult_acc_pipe

Overview:
- Parametrised pipelined multiply-accumulate block for the multiplier micro-benchmark set.
- Generalises the fixed 16-bit unsigned multiplier with:
  - configurable operand width and pipeline depth;
  - per-transaction signed/unsigned selection;
  - multiply-only or accumulate mode;
  - valid/ready flow control with back-pressure.
- The product stage is a plain `*` so synthesis maps it onto the fabric's hard multiplier.

Parameters:
- DATA_WIDTH, 16, operand width in bits (4..32).
- PIPE_STAGES, 2, product pipeline registers between input capture and accumulate stage (1..4).
- ACC_WIDTH, 2*DATA_WIDTH+8, accumulator and output width; must be >= 2*DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the beat.
- mac_mode  input  1  1 = accumulate, 0 = multiply only; sampled with the beat.
- acc_clr  input  1  with an accepted beat, the accumulator restarts from this product.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out  output  ACC_WIDTH  result.
- overflow  output  1  sticky accumulator overflow flag.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high. No other clock or async path.
- Reset:
  - All pipeline valid bits, out_valid, out, overflow and the accumulator go to 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no output is produced for them.
- Pipeline advance:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - A beat is accepted when in_valid & in_ready.
  - Under stall every stage holds, including data, mode bits and out.
- Stage 0, input capture: registers a, b, signed_mode, mac_mode, acc_clr and the valid bit.
- Stages 1..PIPE_STAGES, product:
  - Product is 2*DATA_WIDTH bits.
  - signed_mode=1: operands sign-extended and multiplied as signed.
  - signed_mode=0: multiplied as unsigned.
  - Mode bits travel with the product.
- Accumulate stage, on a valid beat when not stalled:
  - Product is extended to ACC_WIDTH: sign-extend if signed_mode, else zero-extend.
  - mac_mode=0: out <= ext_product; accumulator unchanged.
  - mac_mode=1, acc_clr=1: acc <= ext_product; out <= ext_product; overflow <= 0.
  - mac_mode=1, acc_clr=0: acc <= acc + ext_product, modulo 2^ACC_WIDTH; out <= new acc.
- Overflow detection:
  - Signed: operands have equal sign and the sum sign differs.
  - Unsigned: carry out of the MSB.
  - Detection sets overflow; it stays set until rst or an accepted acc_clr beat with mac_mode=1.
- Latency:
  - Accepted beat appears on out with out_valid=1 exactly PIPE_STAGES+2 cycles after acceptance, when there is no stall.
  - Throughput is one beat per cycle.
- out_valid stays 1 and out stays stable until out_ready=1.
- Bubbles (in_valid=0) propagate as invalid stages; the accumulator is untouched.
- Mixing signed_mode across beats of one accumulation is legal. Each product is extended per its own flag.

Optional Feature:
- Macro MULT_ACC_PIPE_SAT_EN.
- When defined:
  - Accumulate saturates instead of wrapping.
  - Signed: clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned: clamps to 2^ACC_WIDTH-1.
  - overflow is still set on every saturation event.
- When undefined: modulo wrap as in Behaviour. No saturation logic is synthesised.

Test Plan:
- Unsigned multiply, defaults: a=16'hFFFF, b=16'hFFFF, signed_mode=0, mac_mode=0.
  - out=40'h00FFFE0001, out_valid exactly 4 cycles after accept.
- Signed multiply: a=16'hFFFE (-2), b=16'h0003, signed_mode=1, mac_mode=0.
  - out=-6 = 40'hFFFFFFFFFA.
- MAC sequence, signed: beats (3,4,acc_clr=1), (5,6), (-2,7), mac_mode=1.
  - out stream 12, 42, 28; overflow=0.
- Back-pressure: stream 8 beats (a=i, b=1, mac_mode=0) while out_ready is held low for 5 cycles mid-stream.
  - in_ready drops the cycle stall begins.
  - out holds its value during the stall.
  - All 8 results 0..7 delivered in order, none lost or duplicated.
- Overflow, DATA_WIDTH=8, ACC_WIDTH=16, unsigned: accumulate 255*255 three times.
  - Wrap build: out=0xFE01, 0xFC02 (wrapped); overflow=1 after beat 2.
  - SAT_EN build: out saturates at 0xFFFF; overflow=1.
  - A following acc_clr beat clears overflow.
- Reset mid-flight: accept 2 beats, assert rst 1 cycle before the first would emerge.
  - No out_valid afterwards; out=0, overflow=0, in_ready=1 the cycle after rst deasserts.
